// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_if
//  Description : Request/done bus between the MEM-stage sequencer and the
//                multi-cycle data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_done;
  logic [15:0] dm_rdata;

  // Sequencer side: issues the access, receives completion and read data.
  modport master (
    output dm_req, dm_wr, dm_addr, dm_wdata,
    input  dm_done, dm_rdata
  );

  // Memory side.
  modport slave (
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    output dm_done, dm_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM-stage sequencer. Converts load/store control bits into a
//                one-cycle request / done handshake with a multi-cycle data
//                memory, freezes the pipeline while the access is in flight
//                and registers load data for write-back.
//  Options     : MEM_TIMEOUT_EN - abort an access after TMO_CYC wait cycles,
//                pulse err and return 16'hFFFF for an aborted load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int TMO_CYC = 15,
  parameter int TMO_W   = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        mem_rd_i,
  input  wire logic        mem_wr_i,
  input  wire logic [15:0] addr_i,
  input  wire logic [15:0] wdata_i,
  mem_stage_ctrl_if.master dm,
  output logic      [15:0] rdata_o,
  output logic             Stall_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        dm_wr_q;
  logic [15:0] dm_addr_q;
  logic [15:0] dm_wdata_q;
  logic [15:0] rdata_q;
  logic        op_present;

  assign op_present = mem_rd_i | mem_wr_i;

`ifdef MEM_TIMEOUT_EN
  // Counter value seen in the last permitted wait cycle; the abort happens on
  // the edge where the counter would reach TMO_CYC.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
`endif

  // Sequencer state, latched access attributes and captured load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dm_wr_q    <= 1'b0;
      dm_addr_q  <= 16'h0000;
      dm_wdata_q <= 16'h0000;
      rdata_q    <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (op_present) begin
            state_q    <= S_REQ;
            dm_addr_q  <= addr_i;
            dm_wdata_q <= wdata_i;
            // A load wins when both control bits are set.
            dm_wr_q    <= mem_wr_i & ~mem_rd_i;
          end
        end
        S_REQ: begin
          if (dm.dm_done) begin
            state_q <= S_DONE;
            if (!dm_wr_q) rdata_q <= dm.dm_rdata;
          end else begin
            state_q <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A completion in the same cycle as the limit is a normal finish.
          if (dm.dm_done) begin
            state_q <= S_DONE;
            if (!dm_wr_q) rdata_q <= dm.dm_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_DONE;
            err_q   <= 1'b1;
            if (!dm_wr_q) rdata_q <= 16'hFFFF;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        // One free-running cycle so the pipeline advances exactly once;
        // the MEM-stage register still holds the finished instruction here.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request decoded straight from the state register, so it is glitch-free.
  assign dm.dm_req   = (state_q == S_REQ);
  assign dm.dm_wr    = dm_wr_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign rdata_o     = rdata_q;

  // Freeze from the first cycle the op is visible until the access completes.
  assign Stall_o = ((state_q == S_IDLE) & op_present) |
                   (state_q == S_REQ) | (state_q == S_WAIT);

`ifdef MEM_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM pipeline stage. It turns the load/store control bits held in the execute/memory pipeline register into a request/done handshake with a multi-cycle data memory. It drives the pipeline-wide `Stall` that freezes every stage register (their enables are `~Stall`) until the access completes. It also captures load data for write-back.

## Interface

Parameters:
- `TMO_CYC`, default 15: wait-state limit before an access is aborted; used only with `MEM_TIMEOUT_EN`.
- `TMO_W`, default 4: width of the timeout counter; must satisfy 2^TMO_W > TMO_CYC.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `mem_rd`  in  1  — MEM-stage instruction is a load (from the stage control word).
- `mem_wr`  in  1  — MEM-stage instruction is a store.
- `addr`  in  16  — effective address (ALU result of the MEM-stage instruction).
- `wdata`  in  16  — store data (second register-read operand).
- `dm_req`  out  1  — memory request; high for exactly one cycle per access.
- `dm_wr`  out  1  — 1 = write, 0 = read; held from REQ through DONE.
- `dm_addr`  out  16  — latched address; held from REQ through DONE.
- `dm_wdata`  out  16  — latched store data; held from REQ through DONE.
- `dm_done`  in  1  — memory completion pulse; read data is valid on `dm_rdata` in the same cycle.
- `dm_rdata`  in  16  — memory read data.
- `rdata`  out  16  — registered load result to write-back.
- `Stall`  out  1  — pipeline freeze; combinational.
- `err`  out  1  — one-cycle timeout pulse; constant 0 when the feature is compiled out.

## Operation

The block is a four-state FSM: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - If `mem_rd | mem_wr` is set, go to REQ.
  - On that edge, latch `dm_addr <= addr`, `dm_wdata <= wdata`, and `dm_wr <= mem_wr & ~mem_rd`.
  - If both `mem_rd` and `mem_wr` are set, the access is a read.
- **REQ**
  - `dm_req = 1`.
  - If `dm_done` is set in this cycle, go directly to DONE.
  - Otherwise go to WAIT.
- **WAIT**
  - Hold until `dm_done`, then go to DONE.
- **DONE**
  - `Stall = 0`, so the pipeline advances exactly one instruction.
  - The next state is always IDLE.
  - No new access starts in DONE, even if `mem_rd`/`mem_wr` are still set. The MEM-stage register only updates at the end of DONE.

Stall and data rules:
- `Stall = (IDLE & (mem_rd | mem_wr)) | REQ | WAIT`.
- `rdata` loads `dm_rdata` on the edge where `dm_done` is sampled in REQ or WAIT and the access is a read.
- `rdata` is unchanged on writes and holds its value until the next load completes.
- `dm_done` is ignored in IDLE and DONE.

## Timing

- Reset values:
  - State is IDLE.
  - `dm_req`, `dm_wr`, `err` are 0.
  - `dm_addr`, `dm_wdata`, `rdata` are 16'h0000.
  - The timeout counter is 0.
- Reset mid-access returns to IDLE immediately and abandons the outstanding request.
- `Stall` duration:
  - Minimum is 2 cycles (IDLE with the op present, then REQ with `dm_done`), followed by 1 DONE cycle.
  - If `dm_done` arrives n cycles after REQ, `Stall` is high for n+2 cycles.
- Back-to-back memory instructions each cost at least 3 cycles: IDLE, REQ, DONE.
- `dm_req` is decoded from the state register and is glitch-free.

## Configuration

`MEM_TIMEOUT_EN`:
- **Defined:**
  - A TMO_W-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TMO_CYC` without `dm_done`, the FSM goes to DONE.
  - On that DONE entry, `err` pulses for one cycle.
  - If the aborted access was a read, `rdata` loads 16'hFFFF.
  - `dm_done` in the same cycle as the counter reaching `TMO_CYC` counts as a normal completion: no `err`, real data is captured.
- **Undefined:**
  - There is no counter.
  - WAIT holds indefinitely.
  - `err` is tied to 0.

## Test plan

- **Reset:** assert `rst` mid-WAIT → all outputs return to reset values asynchronously; after release the FSM is IDLE and `Stall` = 0 with no op present.
- **Zero-wait load:** `mem_rd` = 1, `addr` = 16'h0040, memory returns `dm_done` in the REQ cycle with `dm_rdata` = 16'hBEEF → `Stall` is high for 2 cycles; the DONE cycle follows with `rdata` = 16'hBEEF and `dm_req` pulsed once.
- **Wait-state store:** `mem_wr` = 1, `addr` = 16'h0010, `wdata` = 16'h1234, `dm_done` 3 cycles after REQ → `dm_wr` = 1 and `dm_addr`/`dm_wdata` stay stable throughout; `Stall` is high for 5 cycles; `rdata` is unchanged.
- **Back-to-back:** a load followed immediately by a store → two distinct `dm_req` pulses separated by DONE and IDLE; no duplicate access of the first instruction.
- **Conflicting controls:** `mem_rd` = `mem_wr` = 1 → a read is issued (`dm_wr` = 0).
- **Timeout** (`MEM_TIMEOUT_EN`, `TMO_CYC` = 15): a load with no `dm_done` → after 15 WAIT cycles, a DONE cycle with `err` = 1 for one cycle and `rdata` = 16'hFFFF; a stray `dm_done` in the following IDLE is ignored.
